// File: rtl/anspwm_combine.sv
// anspwm_combine: final signed-addition and PWM output stage of the
// noise-shaped PWM chain. Sums four sign-magnitude stage outputs, clamps the
// sum into the legal duty range, latches it once per frame and drives pwm.
// Interface contract: tick is a one-cycle strobe, high exactly while
// cnt == 2^CNTW-1; upstream stages advance on it and must present stable
// C*/C*sgn values at least 2 clocks before the frame wrap.
module anspwm_combine #(
  parameter int CNTW = 10,
  parameter int MAGW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [MAGW-1:0] C1,
  input  logic            C1sgn,
  input  logic [MAGW-1:0] C2,
  input  logic            C2sgn,
  input  logic [MAGW-1:0] C3,
  input  logic            C3sgn,
  input  logic [MAGW-1:0] C4,
  input  logic            C4sgn,
  output logic            tick,
  output logic [CNTW:0]   duty,
  output logic            sat,
  output logic            pwm
);

  // Sum width: four MAGW+1 signed terms need two extra bits of headroom.
  localparam int SW = MAGW + 3;

  localparam logic [CNTW-1:0] CNT_MAX   = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_PRE   = {{(CNTW-1){1'b1}}, 1'b0};
  localparam logic [CNTW:0]   DUTY_FULL = {1'b1, {CNTW{1'b0}}};
  localparam logic [SW-2:0]   SUM_FULL  = (SW-1)'(DUTY_FULL);

  logic signed [SW-1:0] t1, t2, t3, t4;
  logic signed [SW-1:0] sum_q;
  logic [CNTW:0]        clamp_val;
  logic                 clamp_sat;
  logic [CNTW:0]        dnext;
  logic                 satnext;
  logic [CNTW-1:0]      cnt;
  logic                 wrap;

  // Sign-magnitude to two's complement; negative zero maps to 0 naturally.
  function automatic logic signed [SW-1:0] to_term(input logic [MAGW-1:0] mag,
                                                   input logic neg);
    logic signed [SW-1:0] ext;
    ext = signed'({3'b000, mag});
    return neg ? -ext : ext;
  endfunction

  // Convert the four stage outputs into signed terms.
  always_comb begin
    t1 = to_term(C1, C1sgn);
    t2 = to_term(C2, C2sgn);
    t3 = to_term(C3, C3sgn);
    t4 = to_term(C4, C4sgn);
  end

  // P1: register the signed sum; its width cannot overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else        sum_q <= t1 + t2 + t3 + t4;
  end

  // Clamp the sum into [0, 2^CNTW] and flag whenever the value was altered.
  always_comb begin
    clamp_val = '0;
    clamp_sat = 1'b0;
    if (sum_q[SW-1]) begin
      clamp_val = '0;
      clamp_sat = 1'b1;
    end else if (sum_q[SW-2:0] > SUM_FULL) begin
      clamp_val = DUTY_FULL;
      clamp_sat = 1'b1;
    end else begin
      clamp_val = sum_q[CNTW:0];
    end
  end

  // P2: register the clamped candidate duty for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dnext   <= '0;
      satnext <= 1'b0;
    end else begin
      dnext   <= clamp_val;
      satnext <= clamp_sat;
    end
  end

  assign wrap = en && (cnt == CNT_MAX);

  // Frame counter: held at 0 while disabled, free-running wrap when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
    else         cnt <= '0;
  end

  // Registered tick: set on the edge that moves cnt into its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick <= 1'b0;
    else        tick <= en && (cnt == CNT_PRE);
  end

  // Latch duty/sat only on the wrap edge so they are constant for a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty <= '0;
      sat  <= 1'b0;
    end else if (wrap) begin
      duty <= dnext;
      sat  <= satnext;
    end
  end

  // Registered PWM compare; duty = 2^CNTW exceeds every cnt so pwm stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm <= 1'b0;
    else        pwm <= en && ({1'b0, cnt} < duty);
  end

endmodule

// File: doc/anspwm_combine.md
Name: anspwm_combine

Overview:
- Final signed-addition and PWM output stage of the noise-shaped PWM chain.
- Consumes the sign-magnitude outputs (C, Csgn) of the four quantize/ddiff stages and sums them into one signed duty value.
- Clamps the sum and latches it once per PWM frame, then drives the PWM pin.
- Emits the frame tick on which the upstream stages advance.

Parameters:
CNTW, 10, PWM counter width; frame period = 2^CNTW clocks.
MAGW, 16, magnitude width of each stage input.

Ports:
clk      in   1      system clock
rst_n    in   1      asynchronous, active-low reset
en       in   1      modulator enable
C1       in   MAGW   stage 1 magnitude
C1sgn    in   1      stage 1 sign (1 = negative)
C2       in   MAGW   stage 2 magnitude
C2sgn    in   1      stage 2 sign
C3       in   MAGW   stage 3 magnitude
C3sgn    in   1      stage 3 sign
C4       in   MAGW   stage 4 magnitude
C4sgn    in   1      stage 4 sign
tick     out  1      one-cycle frame-end strobe to upstream stages
duty     out  CNTW+1 duty value active in the current frame
sat      out  1      active duty was clamped
pwm      out  1      PWM output, registered

Behaviour:
Reset:
- rst_n low asynchronously clears all registers: cnt, pipeline, duty, sat, tick and pwm all go to 0.
- Reset mid-frame aborts the frame. After release, the first frame starts at cnt=0 with duty=0.

Sum pipeline (runs every clock, independent of en):
- P1: each input is converted to signed MAGW+1 bits (negated when its sign bit is 1). The four terms are summed into a signed register of MAGW+3 bits. This width cannot overflow.
- P2: clamp to [0, 2^CNTW]. A negative sum gives 0 and a sum above 2^CNTW gives 2^CNTW; the clamp value is registered as dnext. Set satnext=1 whenever the clamp altered the value.
- Latency from input to dnext is 2 clocks. Inputs must be stable for at least 2 clocks before the frame wrap.
- Negative zero (magnitude 0, sign 1) is treated as 0.

Frame counter:
- en=0: cnt is held at 0, tick=0, pwm=0. duty and sat hold their values.
- en=1: cnt increments by 1 each clock and wraps from 2^CNTW-1 to 0.
- tick=1 is registered and asserted exactly in the cycle where cnt==2^CNTW-1.
- On the edge where cnt wraps to 0, duty<=dnext and sat<=satnext. duty is constant for the whole frame.
- First frame after en rises: cnt starts at 0 using the currently held duty. The first load happens at the end of that frame.
- en falling mid-frame: cnt returns to 0 on the next clock. No tick is emitted and no duty load occurs.

PWM:
- pwm is registered: pwm <= en && (cnt < duty). Output lags cnt by 1 clock.
- duty=0 gives pwm constantly 0.
- duty=2^CNTW gives pwm constantly 1, with no glitch across the wrap.
- High time per frame is exactly duty clocks.

Test Plan:
- CNTW=4. C1=5, all others 0, signs 0, en=1 held 3 frames -> from frame 2: pwm high 5 of 16 clocks per frame, duty=5, sat=0, tick every 16 clocks.
- C1=10, C2=3/sgn=1, C3=2, C4=1/sgn=1 -> duty=8 next frame, pwm high 8 clocks.
- C1=20 -> duty=16, sat=1, pwm constantly 1 across consecutive frames.
- C1=0, C2=7/sgn=1 -> duty=0, sat=1, pwm constantly 0.
- Change C1 from 5 to 9 mid-frame -> duty stays 5 until wrap, then 9. Change 1 clock before wrap -> duty=5 for one more frame.
- Assert rst_n=0 at cnt=7 with pwm high -> all outputs 0 immediately. After release with en=1, first frame has duty=0, then loads the summed value.
